instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 54 +++++
 rtl/instruction_fetch_wait_counter.sv | 32 +++
 rtl/instruction_fetch.sv | 89 ++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the fetch stage: instruction layout, opcode and register
// codes, and fetch FSM state encodings.
package instruction_fetch_pkg;

    localparam int ADDR_W    = 16;
    localparam int OPCODE_W  = 4;
    localparam int OPERAND_W = 24;
    localparam int INSTR_W   = OPCODE_W + OPERAND_W;

    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP = 4'h0,
        OP_LDI = 4'h1,
        OP_STO = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_AND = 4'h5,
        OP_OR  = 4'h6,
        OP_JMP = 4'h7,
        OP_BEQ = 4'h8,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        REG_R0 = 4'h0,
        REG_R1 = 4'h1,
        REG_R2 = 4'h2,
        REG_R3 = 4'h3,
        REG_R4 = 4'h4,
        REG_R5 = 4'h5,
        REG_R6 = 4'h6,
        REG_R7 = 4'h7
    } reg_t;

    localparam logic [0:0] STATE_FETCH = 1'b0;
    localparam logic [0:0] STATE_WAIT  = 1'b1;

    typedef enum logic [0:0] {
        ST_FETCH = STATE_FETCH,
        ST_WAIT  = STATE_WAIT
    } fetch_state_t;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_t'(instr[INSTR_W-1 -: OPCODE_W]);
    endfunction

    function automatic logic [OPERAND_W-1:0] get_operand(input logic [INSTR_W-1:0] instr);
        return instr[OPERAND_W-1:0];
    endfunction

    function automatic logic is_nop(input logic [INSTR_W-1:0] instr);
        return get_opcode(instr) == OP_NOP;
    endfunction

endpackage

// File: rtl/instruction_fetch_wait_counter.sv
// 24-bit loadable down-counter used to time NOP delay slots; done marks the
// final wait cycle.
module wait_counter
    import instruction_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 load,
    input  logic [OPERAND_W-1:0] load_value,
    input  logic                 dec,
    output logic                 done
);

    logic [OPERAND_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A count of zero also reports done so a stray entry into WAIT cannot lock up.
    assign done = (count <= OPERAND_W'(1));

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the ROM address, registers fetched instructions,
// drops NOPs and stretches NOP N into N idle cycles, honours stalls and branches.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'd0
) (
    input  logic               Clock,
    input  logic               Reset,
    output logic [ADDR_W-1:0]  oAddress,
    input  logic [INSTR_W-1:0] iInstruction,
    input  logic               iStall,
    input  logic               iBranchTaken,
    input  logic [ADDR_W-1:0]  iBranchTarget,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oPC,
    output logic               oValid
);

    fetch_state_t         state;
    logic [ADDR_W-1:0]    pc;
    logic                 hold;
    logic                 fetch_is_nop;
    logic [OPERAND_W-1:0] nop_operand;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_done;

    assign oAddress     = pc;
    assign hold         = oValid & iStall;
    assign fetch_is_nop = is_nop(iInstruction);
    assign nop_operand  = get_operand(iInstruction);

    // The counter is loaded only by a NOP that actually gets fetched with a nonzero delay.
    assign cnt_load = (state == ST_FETCH) && !hold && fetch_is_nop && (nop_operand != '0);
    assign cnt_dec  = (state == ST_WAIT);

    wait_counter u_wait_counter (
        .clk        (Clock),
        .rst_n      (Reset),
        .clear      (iBranchTaken),
        .load       (cnt_load),
        .load_value (nop_operand),
        .dec        (cnt_dec),
        .done       (cnt_done)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_FETCH;
            pc           <= RESET_PC;
            oValid       <= 1'b0;
            oInstruction <= '0;
            oPC          <= '0;
        end else if (iBranchTaken) begin
            state  <= ST_FETCH;
            pc     <= iBranchTarget;
            oValid <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (!hold) begin
                        pc <= pc + ADDR_W'(1);
                        if (fetch_is_nop) begin
                            oValid <= 1'b0;
                            if (nop_operand != '0) begin
                                state <= ST_WAIT;
                            end
                        end else begin
                            oInstruction <= iInstruction;
                            oPC          <= pc;
                            oValid       <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    oValid <= 1'b0;
                    if (cnt_done) begin
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, hand-written
// NOP/branch/reset sequences, and a randomized run against a behavioural model.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic        Clock;
    logic        Reset;
    logic        stall;
    logic        br;
    logic [15:0] tgt;

    logic [15:0] addr1, opc1, addr2, opc2;
    logic [27:0] instr1, out_instr1, instr2, out_instr2;
    logic        valid1, valid2;

    logic [27:0] rom [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        stall;
        logic        br;
        logic [15:0] tgt;
        logic        exp_valid;
        logic [15:0] exp_opc;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl [16];

    // model state
    logic [15:0] m_pc, m_opc;
    logic [27:0] m_instr;
    logic        m_valid;
    int unsigned m_delay;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always_comb instr1 = rom[addr1];
    assign instr2 = {OP_ADD, 8'h00, addr2};

    instruction_fetch u_dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (addr1),
        .iInstruction  (instr1),
        .iStall        (stall),
        .iBranchTaken  (br),
        .iBranchTarget (tgt),
        .oInstruction  (out_instr1),
        .oPC           (opc1),
        .oValid        (valid1)
    );

    instruction_fetch #(.RESET_PC(16'hFFFF)) u_dut_hi (
        .Clock         (Clock),
        .Reset         (Reset),
        .oAddress      (addr2),
        .iInstruction  (instr2),
        .iStall        (stall),
        .iBranchTaken  (br),
        .iBranchTarget (tgt),
        .oInstruction  (out_instr2),
        .oPC           (opc2),
        .oValid        (valid2)
    );

    function automatic logic [27:0] mk(input opcode_t op, input logic [23:0] opd);
        return {op, opd};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic [15:0] t);
        stall = s;
        br    = b;
        tgt   = t;
        @(posedge Clock);
        #1;
    endtask

    task automatic loadDefaultRom();
        for (int i = 0; i < 16; i++) rom[i] = mk(OP_ADD, 24'h100 + 24'(i));
    endtask

    task automatic resetDut();
        @(negedge Clock);
        Reset = 1'b0;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 16'd0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    // Reference: NOP N becomes N cycles with no fetch; stall only matters when output is valid.
    task automatic modelStep(input logic s, input logic b, input logic [15:0] t);
        logic [27:0] ins;
        if (b) begin
            m_pc    = t;
            m_valid = 1'b0;
            m_delay = 0;
        end else if (m_delay > 0) begin
            m_delay--;
            m_valid = 1'b0;
        end else if (!(m_valid && s)) begin
            ins = rom[m_pc];
            if (ins[27:24] == 4'(OP_NOP)) begin
                m_valid = 1'b0;
                m_delay = int'(ins[23:0]);
            end else begin
                m_valid = 1'b1;
                m_opc   = m_pc;
                m_instr = ins;
            end
            m_pc = m_pc + 16'd1;
        end
    endtask

    initial begin
        int low;
        stall = 1'b0;
        br    = 1'b0;
        tgt   = 16'd0;
        for (int a = 0; a < 65536; a++) rom[a] = mk(OP_ADD, 24'(a));
        loadDefaultRom();
        rom[0] = mk(OP_STO, 24'h000011);
        rom[1] = mk(OP_ADD, 24'h000022);
        rom[2] = mk(OP_JMP, 24'h000033);

        // asynchronous reset takes effect without any clock edge
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #1;
        checkOutput("rst_valid", 32'(valid1), 32'd0);
        checkOutput("rst_opc", 32'(opc1), 32'd0);
        checkOutput("rst_instr", 32'(out_instr1), 32'd0);
        checkOutput("rst_addr", 32'(addr1), 32'd0);
        checkOutput("rst_addr_hi", 32'(addr2), 32'hFFFF);
        @(negedge Clock);
        Reset = 1'b1;

        // {stall, branch, target, valid, oPC, oAddress}
        tbl[0]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd0, 16'd1};
        tbl[1]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd1, 16'd2};
        tbl[2]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd2, 16'd3};
        tbl[3]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd3, 16'd4};
        tbl[4]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd4, 16'd5};
        tbl[5]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd5, 16'd6};
        tbl[6]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'd6};
        tbl[7]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'd6};
        tbl[8]  = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd5, 16'd6};
        tbl[9]  = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd6, 16'd7};
        tbl[10] = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd6, 16'd7};
        tbl[11] = '{1'b1, 1'b1, 16'd2, 1'b0, 16'd6, 16'd2};
        tbl[12] = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd2, 16'd3};
        tbl[13] = '{1'b1, 1'b0, 16'd0, 1'b1, 16'd2, 16'd3};
        tbl[14] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd3, 16'd4};
        tbl[15] = '{1'b0, 1'b0, 16'd0, 1'b1, 16'd4, 16'd5};

        for (int i = 0; i < 16; i++) begin
            applyStimulus(tbl[i].stall, tbl[i].br, tbl[i].tgt);
            checkOutput($sformatf("vec%0d_valid", i), 32'(valid1), 32'(tbl[i].exp_valid));
            checkOutput($sformatf("vec%0d_opc", i), 32'(opc1), 32'(tbl[i].exp_opc));
            checkOutput($sformatf("vec%0d_addr", i), 32'(addr1), 32'(tbl[i].exp_addr));
            checkOutput($sformatf("vec%0d_instr", i), 32'(out_instr1), 32'(rom[tbl[i].exp_opc]));
        end

        // NOP 4 at address 1: one dropped slot plus four wait cycles
        loadDefaultRom();
        rom[1] = mk(OP_NOP, 24'd4);
        resetDut();
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("nop4_first_opc", 32'(opc1), 32'd0);
        low = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 1'b0, 16'd0);
            if (valid1) break;
            checkOutput("nop4_wait_addr", 32'(addr1), 32'd2);
            low++;
        end
        checkOutput("nop4_low_cycles", 32'(low), 32'd5);
        checkOutput("nop4_next_opc", 32'(opc1), 32'd2);

        // NOP 0 at address 1: exactly one bubble
        rom[1] = mk(OP_NOP, 24'd0);
        resetDut();
        applyStimulus(1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("nop0_bubble_valid", 32'(valid1), 32'd0);
        checkOutput("nop0_bubble_opc", 32'(opc1), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("nop0_next_valid", 32'(valid1), 32'd1);
        checkOutput("nop0_next_opc", 32'(opc1), 32'd2);

        // branch while waiting on NOP 10 at address 3
        loadDefaultRom();
        rom[3] = mk(OP_NOP, 24'd10);
        resetDut();
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("brw_wait_valid", 32'(valid1), 32'd0);
        checkOutput("brw_wait_addr", 32'(addr1), 32'd4);
        applyStimulus(1'b0, 1'b1, 16'd2);
        checkOutput("brw_valid", 32'(valid1), 32'd0);
        checkOutput("brw_addr", 32'(addr1), 32'd2);
        checkOutput("brw_held_opc", 32'(opc1), 32'd2);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("brw_next_valid", 32'(valid1), 32'd1);
        checkOutput("brw_next_opc", 32'(opc1), 32'd2);

        // reset in the middle of a 1000-cycle wait
        loadDefaultRom();
        rom[2] = mk(OP_NOP, 24'd1000);
        resetDut();
        for (int c = 0; c < 5; c++) applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("rmw_pre_opc", 32'(opc1), 32'd1);
        #2 Reset = 1'b0;
        #1;
        checkOutput("rmw_valid", 32'(valid1), 32'd0);
        checkOutput("rmw_opc", 32'(opc1), 32'd0);
        checkOutput("rmw_instr", 32'(out_instr1), 32'd0);
        checkOutput("rmw_addr", 32'(addr1), 32'd0);
        rom[2] = mk(OP_ADD, 24'h000777);
        @(negedge Clock);
        Reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("rmw_first_valid", 32'(valid1), 32'd1);
        checkOutput("rmw_first_opc", 32'(opc1), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("rmw_second_opc", 32'(opc1), 32'd1);

        // RESET_PC = FFFF wraps to 0000
        resetDut();
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("hi_first_valid", 32'(valid2), 32'd1);
        checkOutput("hi_first_opc", 32'(opc2), 32'hFFFF);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("hi_second_opc", 32'(opc2), 32'h0000);
        checkOutput("hi_second_addr", 32'(addr2), 32'h0001);

        // randomized run against the reference model
        for (int a = 0; a < 65536; a++) begin
            if ($urandom_range(0, 9) < 2)
                rom[a] = mk(OP_NOP, 24'($urandom_range(0, 3)));
            else
                rom[a] = {4'($urandom_range(1, 8)), 24'($urandom)};
        end
        resetDut();
        m_pc    = 16'd0;
        m_opc   = 16'd0;
        m_instr = 28'd0;
        m_valid = 1'b0;
        m_delay = 0;
        for (int c = 0; c < 3000; c++) begin
            logic        s, b;
            logic [15:0] t;
            s = ($urandom_range(0, 9) < 3);
            b = ($urandom_range(0, 19) == 0);
            t = 16'($urandom_range(0, 65535));
            applyStimulus(s, b, t);
            modelStep(s, b, t);
            checkOutput($sformatf("rnd%0d_valid", c), 32'(valid1), 32'(m_valid));
            checkOutput($sformatf("rnd%0d_addr", c), 32'(addr1), 32'(m_pc));
            checkOutput($sformatf("rnd%0d_opc", c), 32'(opc1), 32'(m_opc));
            checkOutput($sformatf("rnd%0d_instr", c), 32'(out_instr1), 32'(m_instr));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
